// File: rtl/rob_mc_pkg.sv
// rob_mc_pkg: shared type codes, entry-state encoding and default sizes for the reorder buffer.
package rob_mc_pkg;
  localparam int ROB_DEPTH_DEF = 16;
  localparam int WB_PORTS_DEF = 2;
  typedef enum logic [2:0] {T_NT = 3'd0, T_R, T_I, T_S, T_B, T_U, T_J} rob_type_e;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ISSUED, ST_DONE} rob_state_e;
endpackage

// File: rtl/rob_wb_merge.sv
// rob_wb_merge: priority merge of writeback channels into per-entry write enables and data.
module rob_wb_merge #(
  parameter int DEPTH = 16,
  parameter int W = 4,
  parameter int PORTS = 2
) (
  input  logic [PORTS-1:0]        i_valid,
  input  logic [PORTS*W-1:0]      i_id,
  input  logic [PORTS*32-1:0]     i_value,
  output logic [DEPTH-1:0]        o_we,
  output logic [DEPTH-1:0][31:0]  o_data
);
  // ascending scan: a higher channel overwrites a lower one on the same id
  always_comb begin
    o_we = '0;
    o_data = '0;
    for (int k = 0; k < PORTS; k++)
      if (i_valid[k]) begin
        o_we[i_id[k*W +: W]] = 1'b1;
        o_data[i_id[k*W +: W]] = i_value[k*32 +: 32];
      end
  end
endmodule

// File: rtl/rob_mc.sv
// rob_mc: in-order-retire reorder buffer with branch flush, store handshake and JALR tracking.
// Define ROB_WB_BYPASS_EN to let operand search see same-cycle writebacks.
module rob_mc
  import rob_mc_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEF,
  parameter int ROB_W = $clog2(ROB_DEPTH),
  parameter int WB_PORTS = WB_PORTS_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  output logic [ROB_W-1:0]         issue_rob_id,
  input  logic [2:0]               issue_type,
  input  logic                     issue_is_jalr,
  input  logic [4:0]               issue_rd,
  input  logic [31:0]              issue_val,
  input  logic [31:0]              issue_pred_addr,
  input  logic                     issue_done,
  input  logic [WB_PORTS-1:0]      wb_valid,
  input  logic [WB_PORTS*ROB_W-1:0] wb_rob_id,
  input  logic [WB_PORTS*32-1:0]   wb_value,
  output logic                     commit_valid,
  output logic [ROB_W-1:0]         commit_rob_id,
  output logic [4:0]               commit_rd,
  output logic [31:0]              commit_val,
  output logic                     store_commit_valid,
  input  logic                     store_commit_ready,
  output logic                     flush,
  output logic [31:0]              flush_pc,
  output logic                     melt,
  output logic [ROB_W:0]           count,
  input  logic [ROB_W-1:0]         search_id_1,
  input  logic [ROB_W-1:0]         search_id_2,
  output logic                     search_ready_1,
  output logic                     search_ready_2,
  output logic [31:0]              search_val_1,
  output logic [31:0]              search_val_2
);
  localparam logic [ROB_W:0] FULL = (ROB_W+1)'(ROB_DEPTH);
  rob_state_e r_state [ROB_DEPTH];
  logic [2:0]  r_type [ROB_DEPTH];
  logic [4:0]  r_rd [ROB_DEPTH];
  logic [31:0] r_val [ROB_DEPTH];
  logic [31:0] r_pred [ROB_DEPTH];
  logic        r_jalr [ROB_DEPTH];
  logic [ROB_W-1:0] r_head, r_tail, r_commit_rob_id;
  logic [ROB_W:0]   r_count, r_jalr_cnt;
  logic        r_commit_valid, r_flush;
  logic [4:0]  r_commit_rd;
  logic [31:0] r_commit_val, r_flush_pc;
  logic [ROB_DEPTH-1:0]       w_we;
  logic [ROB_DEPTH-1:0][31:0] w_wd;
  logic w_issue, w_retire, w_commit, w_mispredict, w_store_head, w_jinc, w_jdec, w_live;
  rob_state_e w_head_state;
  logic [2:0] w_head_type;
  rob_wb_merge #(.DEPTH(ROB_DEPTH), .W(ROB_W), .PORTS(WB_PORTS)) u_merge (
    .i_valid(wb_valid), .i_id(wb_rob_id), .i_value(wb_value), .o_we(w_we), .o_data(w_wd)
  );
  assign w_live = rdy_in && !r_flush;
  assign w_head_state = r_state[r_head];
  assign w_head_type = r_type[r_head];
  assign w_store_head = w_head_type == T_S && w_head_state != ST_EMPTY;
  assign issue_ready = r_count != FULL && !r_flush;
  assign w_issue = issue_valid && issue_ready;
  // stores retire on the LSB handshake regardless of writeback state
  assign w_retire = !r_flush && ((w_head_type != T_S && w_head_state == ST_DONE) ||
                    (w_store_head && store_commit_ready));
  assign w_commit = w_retire && w_head_type != T_S && w_head_type != T_B;
  assign w_mispredict = w_retire && w_head_type == T_B && r_val[r_head] != r_pred[r_head];
  assign w_jinc = w_issue && issue_is_jalr;
  assign w_jdec = w_retire && r_jalr[r_head];
  assign store_commit_valid = w_store_head && !r_flush;
  assign issue_rob_id = r_tail;
  assign count = r_count;
  assign melt = r_jalr_cnt == '0;
  assign commit_valid = r_commit_valid;
  assign commit_rob_id = r_commit_rob_id;
  assign commit_rd = r_commit_rd;
  assign commit_val = r_commit_val;
  assign flush = r_flush;
  assign flush_pc = r_flush_pc;
`ifdef ROB_WB_BYPASS_EN
  logic w_byp_1, w_byp_2;
  assign w_byp_1 = w_live && w_we[search_id_1] && r_state[search_id_1] == ST_ISSUED;
  assign w_byp_2 = w_live && w_we[search_id_2] && r_state[search_id_2] == ST_ISSUED;
  assign search_ready_1 = r_state[search_id_1] == ST_DONE || w_byp_1;
  assign search_ready_2 = r_state[search_id_2] == ST_DONE || w_byp_2;
  assign search_val_1 = w_byp_1 ? w_wd[search_id_1] : r_val[search_id_1];
  assign search_val_2 = w_byp_2 ? w_wd[search_id_2] : r_val[search_id_2];
`else
  assign search_ready_1 = r_state[search_id_1] == ST_DONE;
  assign search_ready_2 = r_state[search_id_2] == ST_DONE;
  assign search_val_1 = r_val[search_id_1];
  assign search_val_2 = r_val[search_id_2];
`endif
  // entry payload carries no reset: validity is owned by r_state
  always_ff @(posedge clk_in) begin
    if (w_live) begin
      for (int i = 0; i < ROB_DEPTH; i++)
        if (w_we[i] && r_state[i] == ST_ISSUED) r_val[i] <= w_wd[i];
      if (w_issue) begin
        r_type[r_tail] <= issue_type;
        r_rd[r_tail] <= issue_rd;
        r_val[r_tail] <= issue_val;
        r_pred[r_tail] <= issue_pred_addr;
        r_jalr[r_tail] <= issue_is_jalr;
      end
    end
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < ROB_DEPTH; i++) r_state[i] <= ST_EMPTY;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_jalr_cnt <= '0;
      r_commit_valid <= 1'b0;
      r_commit_rob_id <= '0;
      r_commit_rd <= '0;
      r_commit_val <= '0;
      r_flush <= 1'b0;
      r_flush_pc <= '0;
    end else if (rdy_in && r_flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) r_state[i] <= ST_EMPTY;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_jalr_cnt <= '0;
      r_commit_valid <= 1'b0;
      r_commit_rob_id <= '0;
      r_commit_rd <= '0;
      r_commit_val <= '0;
      r_flush <= 1'b0;
      r_flush_pc <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < ROB_DEPTH; i++)
        if (w_we[i] && r_state[i] == ST_ISSUED) r_state[i] <= ST_DONE;
      if (w_retire) r_state[r_head] <= ST_EMPTY;
      if (w_issue) r_state[r_tail] <= issue_done ? ST_DONE : ST_ISSUED;
      r_head <= w_retire ? r_head + ROB_W'(1) : r_head;
      r_tail <= w_issue ? r_tail + ROB_W'(1) : r_tail;
      r_count <= r_count + (ROB_W+1)'(w_issue) - (ROB_W+1)'(w_retire);
      r_jalr_cnt <= r_jalr_cnt + (ROB_W+1)'(w_jinc) - (ROB_W+1)'(w_jdec);
      r_commit_valid <= w_commit;
      r_commit_rob_id <= w_commit ? r_head : r_commit_rob_id;
      r_commit_rd <= w_commit ? r_rd[r_head] : r_commit_rd;
      r_commit_val <= w_commit ? r_val[r_head] : r_commit_val;
      r_flush <= w_mispredict;
      r_flush_pc <= w_mispredict ? r_val[r_head] : r_flush_pc;
    end
  end
endmodule
